// File: rtl/axonerve_kvs_rtl_burst_pkg.sv
// Shared types and helpers for the KVS burst issuer: FSM states, default burst
// geometry and the AXI len computation for the next burst.
package axonerve_kvs_rtl_burst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } burst_state_e;

  localparam int unsigned LP_BURST_LEN      = 16;
  localparam int unsigned LP_BYTES_PER_BEAT = 64;
  localparam int unsigned LP_BURST_BYTES    = LP_BURST_LEN * LP_BYTES_PER_BEAT;

  // AXI len (beats-1) of the next burst; callers only pass a nonzero remaining.
  function automatic logic [7:0] f_burst_len(input logic [63:0] remaining,
                                             input int unsigned burst_len);
    if (remaining >= 64'(burst_len)) begin
      return 8'(burst_len - 1);
    end
    return 8'(remaining - 64'd1);
  endfunction

endpackage

// File: rtl/axonerve_kvs_rtl_outstanding_tracker.sv
// Up/down counter of issued-but-uncompleted bursts; simultaneous incr/decr
// cancel, decr at zero and incr at the limit are dropped.
module axonerve_kvs_rtl_outstanding_tracker #(
  parameter int unsigned C_MAX   = 16,
  parameter int unsigned C_CNT_W = $clog2(C_MAX) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               incr,
  input  logic               decr,
  output logic [C_CNT_W-1:0] count,
  output logic [C_CNT_W-1:0] count_next,
  output logic               is_full,
  output logic               is_zero
);

  localparam logic [C_CNT_W-1:0] LP_MAX = C_CNT_W'(C_MAX);

  always_comb begin
    count_next = count;
    if (incr && !decr && (count != LP_MAX)) begin
      count_next = count + C_CNT_W'(1);
    end else if (decr && !incr && (count != '0)) begin
      count_next = count - C_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  assign is_full = (count == LP_MAX);
  assign is_zero = (count == '0);

endmodule

// File: rtl/axonerve_kvs_rtl_burst_issuer.sv
// Splits a start request into AXI bursts of at most C_BURST_LEN beats, throttles
// on in-flight bursts and pulses ctrl_done once every burst has completed.
module axonerve_kvs_rtl_burst_issuer
  import axonerve_kvs_rtl_burst_pkg::*;
#(
  parameter int unsigned C_ADDR_WIDTH      = 64,
  parameter int unsigned C_XFER_WIDTH      = 32,
  parameter int unsigned C_BYTES_PER_BEAT  = 64,
  parameter int unsigned C_BURST_LEN       = 16,
  parameter int unsigned C_MAX_OUTSTANDING = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 ctrl_start,
  input  logic [C_ADDR_WIDTH-1:0]              ctrl_addr,
  input  logic [C_XFER_WIDTH-1:0]              ctrl_xfer_beats,
  output logic                                 ctrl_done,
  output logic                                 busy,
  output logic                                 cmd_valid,
  input  logic                                 cmd_ready,
  output logic [C_ADDR_WIDTH-1:0]              cmd_addr,
  output logic [7:0]                           cmd_len,
  input  logic                                 cmp_valid,
  output logic [$clog2(C_MAX_OUTSTANDING):0]   outstanding
);

  localparam int unsigned LP_CNT_W = $clog2(C_MAX_OUTSTANDING) + 1;
  localparam logic [C_ADDR_WIDTH-1:0] LP_STEP =
    C_ADDR_WIDTH'(C_BURST_LEN * C_BYTES_PER_BEAT);
  localparam logic [LP_CNT_W-1:0] LP_MAX = LP_CNT_W'(C_MAX_OUTSTANDING);

  burst_state_e            state;
  logic [C_XFER_WIDTH-1:0] remaining;
  logic [C_XFER_WIDTH-1:0] issued;
  logic [C_XFER_WIDTH-1:0] rem_after;
  logic                    hs;
  logic [LP_CNT_W-1:0]     cnt_next;
  logic                    cnt_full;
  logic                    cnt_zero;

  // A command transfers on any rising edge where cmd_valid && cmd_ready; once
  // raised, cmd_valid/cmd_addr/cmd_len are held until that edge, and cmd_valid
  // is a register so it never follows cmd_ready combinationally.
  assign hs        = cmd_valid && cmd_ready;
  assign issued    = C_XFER_WIDTH'(cmd_len) + C_XFER_WIDTH'(1);
  assign rem_after = remaining - issued;

  axonerve_kvs_rtl_outstanding_tracker #(
    .C_MAX   (C_MAX_OUTSTANDING),
    .C_CNT_W (LP_CNT_W)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .incr       (hs),
    .decr       (cmp_valid),
    .count      (outstanding),
    .count_next (cnt_next),
    .is_full    (cnt_full),
    .is_zero    (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      ctrl_done <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_addr  <= '0;
      cmd_len   <= '0;
      remaining <= '0;
    end else begin
      ctrl_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // The completion pulse cycle also refuses a new start.
          if (ctrl_start && !ctrl_done) begin
            busy      <= 1'b1;
            cmd_addr  <= ctrl_addr;
            remaining <= ctrl_xfer_beats;
            if (ctrl_xfer_beats == '0) begin
              state <= ST_DONE;
            end else begin
              state     <= ST_ISSUE;
              cmd_valid <= 1'b1;
              cmd_len   <= f_burst_len(64'(ctrl_xfer_beats), C_BURST_LEN);
            end
          end
        end
        ST_ISSUE: begin
          if (hs) begin
            cmd_addr  <= cmd_addr + LP_STEP;
            remaining <= rem_after;
            if (rem_after == '0) begin
              cmd_valid <= 1'b0;
              state     <= ST_DRAIN;
            end else begin
              cmd_len   <= f_burst_len(64'(rem_after), C_BURST_LEN);
              cmd_valid <= (cnt_next != LP_MAX);
            end
          end else if (!cmd_valid) begin
            // Stalled on the limit: re-arm as soon as a completion frees a slot.
            cmd_valid <= !(cnt_full && !cmp_valid);
          end
        end
        ST_DRAIN: begin
          if (cnt_zero) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          ctrl_done <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
